// File: rtl/dog_extrema_finder_pkg.sv
// rtl/dog_extrema_finder_pkg.sv - shared types, constants and helpers for the DoG extrema finder
//
// Purpose : DoG sample type, FSM state encoding, FETCH timing constants and
//           a 10-bit magnitude helper used by the contrast test.
// Ports   : none (package)

package dog_extrema_finder_pkg;

   localparam int DOG_W           = 9;
   localparam int BRAM_RD_LATENCY = 2;
   localparam int NB_TAPS         = 9;                             // 3x3 window per layer
   localparam int CENTRE_TAP      = 4;                             // (dy,dx) = (0,0)
   localparam int FETCH_LAST      = NB_TAPS - 1 + BRAM_RD_LATENCY; // last FETCH cycle (10)

   typedef logic signed [DOG_W-1:0] dog_pix_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EVAL,
      EMIT,
      DONE
   } extrema_state_t;

   // Magnitude is widened by one bit so that |-256| = 256 is representable.
   function automatic logic [DOG_W:0] dog_abs(input dog_pix_t p);
      logic signed [DOG_W:0] e;
      e = {p[DOG_W-1], p};
      return e[DOG_W] ? (DOG_W+1)'(-e) : (DOG_W+1)'(e);
   endfunction

endpackage

// File: rtl/dog_extrema_finder_if.sv
// rtl/dog_extrema_finder_if.sv - control, BRAM read and keypoint stream bundle of the extrema finder
//
// Purpose : groups every non-clock/reset signal of dog_extrema_finder.
// Signals : start               scan request pulse
//           rd_addr             shared read address to the three DoG BRAMs
//           prev/cur/next_pix   signed DoG samples, 2 cycles after rd_addr
//           busy, done          scan status / completion pulse
//           kp_valid, kp_ready  keypoint handshake
//           kp_x, kp_y          keypoint coordinates
// Modports: slave  - the extrema finder
//           master - the surrounding system (DoG BRAMs, sequencer, keypoint consumer)

interface dog_extrema_finder_if
   import dog_extrema_finder_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int COORD_W = 6
);

   logic               start;
   logic [ADDR_W-1:0]  rd_addr;
   dog_pix_t           prev_pix;
   dog_pix_t           cur_pix;
   dog_pix_t           next_pix;
   logic               busy;
   logic               kp_valid;
   logic               kp_ready;
   logic [COORD_W-1:0] kp_x;
   logic [COORD_W-1:0] kp_y;
   logic               done;

   modport slave (
      input  start, prev_pix, cur_pix, next_pix, kp_ready,
      output rd_addr, busy, kp_valid, kp_x, kp_y, done
   );

   modport master (
      output start, prev_pix, cur_pix, next_pix, kp_ready,
      input  rd_addr, busy, kp_valid, kp_x, kp_y, done
   );

endinterface

// File: rtl/dog_extrema_finder_minmax_acc.sv
// rtl/dog_extrema_finder_minmax_acc.sv - running signed max/min over several sample lanes per cycle
//
// Purpose : accumulates the maximum and minimum of all enabled lanes since the
//           last clear. Lanes let prev/cur/next of one tap be folded in one cycle.
// Ports   : clk, rst_in     clock, async active-low reset
//           i_clear         restart accumulation (priority over i_enable)
//           i_enable        fold the enabled lanes this cycle
//           i_lane_en       per-lane participation mask
//           i_sample        one signed sample per lane
//           o_max, o_min    running extrema

module dog_extrema_finder_minmax_acc
   import dog_extrema_finder_pkg::*;
#(
   parameter int LANES = 3
)(
   input  logic             clk,
   input  logic             rst_in,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [LANES-1:0] i_lane_en,
   input  dog_pix_t         i_sample [LANES],
   output dog_pix_t         o_max,
   output dog_pix_t         o_min
);

   // Identity values: any real sample replaces them.
   localparam dog_pix_t PIX_MOST_NEG = {1'b1, {(DOG_W-1){1'b0}}};
   localparam dog_pix_t PIX_MOST_POS = {1'b0, {(DOG_W-1){1'b1}}};

   dog_pix_t r_max;
   dog_pix_t r_min;
   dog_pix_t w_max;
   dog_pix_t w_min;

   always_comb begin
      w_max = r_max;
      w_min = r_min;
      for (int i = 0; i < LANES; i++) begin
         if (i_lane_en[i]) begin
            if (i_sample[i] > w_max) w_max = i_sample[i];
            if (i_sample[i] < w_min) w_min = i_sample[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_max <= PIX_MOST_NEG;
         r_min <= PIX_MOST_POS;
      end else if (i_clear) begin
         r_max <= PIX_MOST_NEG;
         r_min <= PIX_MOST_POS;
      end else if (i_enable) begin
         r_max <= w_max;
         r_min <= w_min;
      end
   end

   assign o_max = r_max;
   assign o_min = r_min;

endmodule

// File: rtl/dog_extrema_finder.sv
// rtl/dog_extrema_finder.sv - scale-space extrema detector over three DoG layers
//
// Purpose : after start, visits every interior centre of the cur layer in raster
//           order, reads its 3x3x3 neighbourhood through one shared BRAM address,
//           and streams out (x,y) of strict extrema whose magnitude beats THRESHOLD.
// Ports   : clk     system clock
//           rst_in  asynchronous active-low reset
//           bus     dog_extrema_finder_if.slave (start, rd_addr, prev/cur/next_pix,
//                   busy, kp_valid/kp_ready, kp_x/kp_y, done)

module dog_extrema_finder
   import dog_extrema_finder_pkg::*;
#(
   parameter int DIMENSION = 64,
   parameter int THRESHOLD = 8,
   parameter int ADDR_W    = 12,
   parameter int COORD_W   = 6
)(
   input  logic                 clk,
   input  logic                 rst_in,
   dog_extrema_finder_if.slave  bus
);

   localparam logic [COORD_W-1:0] LAST_C    = COORD_W'(DIMENSION - 2);
   localparam logic [DOG_W:0]     THR_MAG   = (DOG_W+1)'(THRESHOLD);
   localparam logic [3:0]         CYC_LAST  = 4'(FETCH_LAST);
   localparam logic [3:0]         TAP_LAST  = 4'(NB_TAPS - 1);
   localparam logic [3:0]         CAP_FIRST = 4'(BRAM_RD_LATENCY);

   extrema_state_t     r_state;
   extrema_state_t     w_state_nxt;

   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [3:0]         r_cyc;
   dog_pix_t           r_centre;
   logic [COORD_W-1:0] r_kp_x;
   logic [COORD_W-1:0] r_kp_y;

   logic               w_last_centre;
   logic               w_advance;
   logic               w_take_kp;
   logic               w_clear;
   logic               w_capture;
   logic               w_centre_cap;
   logic [2:0]         w_lane_en;
   logic [3:0]         w_tap;
   logic [3:0]         w_k;
   logic [1:0]         w_row;
   logic [1:0]         w_col;
   logic [ADDR_W-1:0]  w_ay;
   logic [ADDR_W-1:0]  w_ax;
   logic [ADDR_W-1:0]  w_addr;
   logic [DOG_W:0]     w_mag;
   logic               w_is_kp;
   dog_pix_t           w_max;
   dog_pix_t           w_min;
   dog_pix_t           w_lane [3];

   // ---------------------------------------------------------------- address
   // Taps 0..8 are issued on FETCH cycles 0..8; afterwards (and outside FETCH)
   // the address simply holds, which keeps it frozen during an EMIT stall.
   always_comb begin
      w_k   = (r_cyc > TAP_LAST) ? TAP_LAST : r_cyc;
      w_row = (w_k >= 4'd6) ? 2'd2 : ((w_k >= 4'd3) ? 2'd1 : 2'd0);
      w_col = 2'(w_k - {2'b00, w_row} * 4'd3);
      // Centres are interior, so y-1+row and x-1+col stay inside the image.
      w_ay   = ADDR_W'(r_y) + ADDR_W'(w_row) - ADDR_W'(1);
      w_ax   = ADDR_W'(r_x) + ADDR_W'(w_col) - ADDR_W'(1);
      w_addr = w_ay * ADDR_W'(DIMENSION) + w_ax;
   end

   // ---------------------------------------------------------------- compare
   assign w_mag   = dog_abs(r_centre);
   assign w_is_kp = ((r_centre > w_max) || (r_centre < w_min)) && (w_mag > THR_MAG);

   assign w_lane[0] = bus.prev_pix;
   assign w_lane[1] = bus.cur_pix;
   assign w_lane[2] = bus.next_pix;

   dog_extrema_finder_minmax_acc #(.LANES(3)) u_acc (
      .clk       (clk),
      .rst_in    (rst_in),
      .i_clear   (w_clear),
      .i_enable  (w_capture),
      .i_lane_en (w_lane_en),
      .i_sample  (w_lane),
      .o_max     (w_max),
      .o_min     (w_min)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_advance     = 1'b0;
      w_take_kp     = 1'b0;
      w_clear       = 1'b0;
      w_capture     = 1'b0;
      w_centre_cap  = 1'b0;
      w_lane_en     = 3'b000;
      w_tap         = r_cyc - CAP_FIRST;
      w_last_centre = (r_x == LAST_C) && (r_y == LAST_C);

      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = FETCH;
         end
         FETCH: begin
            w_clear = (r_cyc == 4'd0);
            // Data for tap k returns BRAM_RD_LATENCY cycles after it was addressed.
            if (r_cyc >= CAP_FIRST) begin
               w_capture    = 1'b1;
               w_centre_cap = (w_tap == 4'(CENTRE_TAP));
               // The centre itself is excluded from its own neighbourhood.
               w_lane_en    = {1'b1, ~w_centre_cap, 1'b1};
            end
            if (r_cyc == CYC_LAST) w_state_nxt = EVAL;
         end
         EVAL: begin
            if (w_is_kp) begin
               w_take_kp   = 1'b1;
               w_state_nxt = EMIT;
            end else begin
               w_advance   = 1'b1;
               w_state_nxt = w_last_centre ? DONE : FETCH;
            end
         end
         EMIT: begin
            if (bus.kp_ready) begin
               w_advance   = 1'b1;
               w_state_nxt = w_last_centre ? DONE : FETCH;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_x      <= COORD_W'(1);
         r_y      <= COORD_W'(1);
         r_cyc    <= 4'd0;
         r_centre <= '0;
         r_kp_x   <= '0;
         r_kp_y   <= '0;
      end else begin
         if (r_state == FETCH) begin
            r_cyc <= (r_cyc == CYC_LAST) ? 4'd0 : r_cyc + 4'd1;
         end
         if (w_centre_cap) begin
            r_centre <= bus.cur_pix;
         end
         if (w_take_kp) begin
            r_kp_x <= r_x;
            r_kp_y <= r_y;
         end
         // The last centre wraps back to (1,1), ready for the next scan.
         if (w_advance) begin
            if (r_x == LAST_C) begin
               r_x <= COORD_W'(1);
               r_y <= (r_y == LAST_C) ? COORD_W'(1) : r_y + COORD_W'(1);
            end else begin
               r_x <= r_x + COORD_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.rd_addr  = w_addr;
   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = (r_state == DONE);
   assign bus.kp_valid = (r_state == EMIT);
   assign bus.kp_x     = r_kp_x;
   assign bus.kp_y     = r_kp_y;

endmodule
